dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//   Shares the single-port word data memory (combinational read, synchronous write) between two
//   requesters: port 0 = CPU MEM stage, port 1 = DMA/debug loader. Round-robin arbitration with a
//   req/ack handshake; one access per grant, registered read data, alignment/range checking.
//   Sits between the pipeline MEM stage / loader and the DM instance; CPU stalls while req0 && !ack0.
// PARAMETERS
//   DEPTH      3072  memory depth in 32-bit words; valid byte addresses 0 .. DEPTH*4-4
//   IDX_W      12    word-index width driven to memory (addr[IDX_W+1:2])
// PORTS
//   clk        in   1      clock, all state on rising edge
//   reset      in   1      synchronous, active-high
//   req0/req1  in   1      access request; held with we/addr/wdata stable until ack or err
//   we0/we1    in   1      1 = store word, 0 = load word
//   addr0/addr1 in  32     byte address
//   wdata0/wdata1 in 32    store data
//   pc0        in   32     CPU PC, forwarded to memory for store trace (port 1 forwards 0)
//   ack0/ack1  out  1      one-cycle pulse: access completed
//   err0/err1  out  1      one-cycle pulse: access rejected (misaligned or out of range), no write
//   rdata0/rdata1 out 32   load data, valid while ackN=1; holds last value otherwise
//   mem_addr   out  32     byte address to DM
//   mem_wdata  out  32     store data to DM
//   mem_we     out  1      DM write enable
//   mem_pc     out  32     PC to DM for trace
//   mem_rdata  in   32     DM combinational read data
//   busy       out  1      1 in RESP state
// BEHAVIOUR
//   FSM: IDLE, RESP. Reset -> IDLE, prio pointer = port 0, ack*/err*/busy = 0, rdata* = 0,
//     mem_we = 0, mem_addr/mem_wdata/mem_pc = 0.
//   IDLE, no req: mem_* idle (mem_we=0); stay IDLE.
//   IDLE, req present: winner = only requester, or if both, port named by prio pointer.
//     Same cycle (N): mem_addr/mem_wdata/mem_pc driven from winner; address valid when
//     addr[1:0]==0 and addr < DEPTH*4. mem_we = we_winner && valid.
//     Posedge end of N: rdata_winner <= mem_rdata (load, valid); prio <= other port; -> RESP.
//   RESP (cycle N+1): exactly one of ackW (valid) / errW (invalid) = 1; busy = 1; no grant,
//     mem_we = 0 (stale req still high is not re-served); -> IDLE. Max throughput 1 access / 2 cycles.
//   Stores: data visible to a load issued in any later grant. Load on store cycle never occurs.
//   Fairness: under continuous req0 && req1 grants alternate 0,1,0,1; wait bound = 3 cycles.
//   Priority pointer only moves on a grant; a single requester does not starve the other.
//   Requester drops req before ack: illegal; behaviour unspecified except no write beyond cycle N.
//   Reset mid-operation (in RESP): ack/err suppressed, state -> IDLE, completed write stays in DM.
//   Errors: misaligned or out-of-range address -> errW pulse, no mem_we, rdata unchanged.
//   Widths: memory index = addr[IDX_W+1:2]; upper bits only used for range check.
// TESTING
//   Reset, req0 store 0x10<=0xDEADBEEF -> mem_we=1 in cycle N only, ack0 pulse N+1, ack1=0.
//   req0 load 0x10 after store -> ack0 at N+1, rdata0=0xDEADBEEF; mem_we stays 0.
//   req0,req1 held together 8 cycles -> ack order 0,1,0,1; each ack one cycle, 2-cycle spacing.
//   req1 store addr 0x13 / addr 0x3000 -> err1 pulse, no ack1, mem_we never 1, DM unchanged.
//   Reset asserted in RESP after store 0x20<=5 -> no ack0; load 0x20 later returns 5; prio=port0.
//   req1 alone 3 accesses then req0+req1 same cycle -> port 0 granted first (pointer after port1).

Source files
------------

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - two-port round-robin arbiter in front of the single-port word data memory
// One access per grant: drive memory in the grant cycle, ack/err pulse in the following RESP cycle.
module dm_port_arbiter #(
    parameter int DEPTH = 3072,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [31:0] pc0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        win_q, win_d;
    logic        ok_q, ok_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        win;
    logic        w_we;
    logic        w_ok;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        win_d     = win_q;
        ok_d      = ok_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        ack0      = 1'b0;
        err0      = 1'b0;
        ack1      = 1'b0;
        err1      = 1'b0;
        busy      = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_we    = 1'b0;
        mem_pc    = 32'd0;

        // Contention is settled by the pointer; a lone requester always wins.
        win     = (req0 && req1) ? prio_q : req1;
        w_we    = win ? we1 : we0;
        w_addr  = win ? addr1 : addr0;
        w_wdata = win ? wdata1 : wdata0;
        w_ok    = (w_addr[1:0] == 2'b00) && (w_addr < ADDR_LIMIT);

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    mem_addr  = {{(30 - IDX_W){1'b0}}, w_addr[IDX_W+1:2], 2'b00};
                    mem_wdata = w_wdata;
                    mem_pc    = win ? 32'd0 : pc0;
                    mem_we    = w_we && w_ok;
                    win_d     = win;
                    ok_d      = w_ok;
                    prio_d    = ~win;
                    state_d   = S_RESP;
                    if (!w_we && w_ok) begin
                        if (win) rdata1_d = mem_rdata;
                        else     rdata0_d = mem_rdata;
                    end
                end
            end
            S_RESP: begin
                busy    = 1'b1;
                ack0    = ok_q  && !win_q;
                err0    = !ok_q && !win_q;
                ack1    = ok_q  && win_q;
                err1    = !ok_q && win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset wins over everything visible, including a response already in flight.
        if (reset) begin
            ack0      = 1'b0;
            err0      = 1'b0;
            ack1      = 1'b0;
            err1      = 1'b0;
            busy      = 1'b0;
            mem_addr  = 32'd0;
            mem_wdata = 32'd0;
            mem_we    = 1'b0;
            mem_pc    = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            win_q    <= 1'b0;
            ok_q     <= 1'b0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            win_q    <= win_d;
            ok_q     <= ok_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - scoreboard bench for dm_port_arbiter with a behavioural data memory
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, pc0, addr1, wdata1;
    logic        ack0, err0, ack1, err1, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_pc, mem_rdata;

    dm_port_arbiter #(.DEPTH(3072), .IDX_W(12)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .pc0(pc0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_pc(mem_pc),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] dm [0:3071];
    logic [11:0] dm_idx;
    assign dm_idx    = mem_addr[13:2];
    assign mem_rdata = (dm_idx < 12'd3072) ? dm[dm_idx] : 32'd0;
    always @(posedge clk) if (mem_we && dm_idx < 12'd3072) dm[dm_idx] <= mem_wdata;

    typedef struct packed {
        logic        port;
        logic        is_err;
        logic [31:0] rdata;
    } resp_t;

    resp_t sb[$];
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (!reset && (ack0 || err0 || ack1 || err1)) begin
            resp_t e;
            logic  p, ie, multi;
            logic [31:0] rd;
            checks++;
            p     = ack1 || err1;
            ie    = err0 || err1;
            rd    = p ? rdata1 : rdata0;
            multi = ((ack0 || err0) && (ack1 || err1)) || (ack0 && err0) || (ack1 && err1);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp port %0d err %0d rdata %h", p, ie, rd);
            end else begin
                e = sb.pop_front();
                if (multi || p !== e.port || ie !== e.is_err || rd !== e.rdata) begin
                    errors++;
                    $display("FAIL resp got port %0d err %0d rdata %h multi %0d expected port %0d err %0d rdata %h",
                             p, ie, rd, multi, e.port, e.is_err, e.rdata);
                end
            end
        end
    end

    task automatic drive(input logic p, input logic r, input logic we, input logic [31:0] a, input logic [31:0] wd);
        if (p) begin req1 = r; we1 = we; addr1 = a; wdata1 = wd; end
        else   begin req0 = r; we0 = we; addr0 = a; wdata0 = wd; end
    endtask

    // Entered and left one time unit after a rising edge with the arbiter idle.
    task automatic access(input logic p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd);
        int  w0;
        bit  done;
        w0 = we_cnt;
        sb.push_back('{port: p, is_err: exp_err, rdata: exp_rd});
        drive(p, 1'b1, we, a, wd);
        #1;
        chk("grant_mem_we", {31'd0, mem_we}, {31'd0, we && !exp_err});
        chk("grant_mem_pc", mem_pc, p ? 32'd0 : pc0);
        if (!exp_err) chk("grant_mem_addr", mem_addr, a);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(posedge clk); #1;
            if (p ? (ack1 || err1) : (ack0 || err0)) done = 1;
        end
        if (!done) chk("access_timeout", 32'd0, 32'd1);
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        chk("store_count", we_cnt - w0, (we && !exp_err) ? 1 : 0);
    endtask

    task automatic both_loads(input logic [31:0] a0, input logic [31:0] a1, input int ncyc,
                              output logic [7:0] ack0_pat, output logic [7:0] ack1_pat, output logic [7:0] busy_pat);
        ack0_pat = 8'd0; ack1_pat = 8'd0; busy_pat = 8'd0;
        drive(1'b0, 1'b1, 1'b0, a0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, a1, 32'd0);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            ack0_pat[k] = ack0; ack1_pat[k] = ack1; busy_pat[k] = busy;
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] pa0, pa1, pb;
        int w0;
        for (int i = 0; i < 3072; i++) dm[i] = 32'd0;
        reset = 1'b1;
        pc0   = 32'h0000_0400;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
        #1;
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("reset_outs", {26'd0, ack0, err0, ack1, err1, busy, mem_we}, 32'd0);
        chk("reset_rdata0", rdata0, 32'd0);
        chk("reset_rdata1", rdata1, 32'd0);
        chk("reset_dm_clean", dm[4], 32'd0);
        @(posedge clk); #1;

        access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0);
        chk("dm_store", dm[4], 32'hDEAD_BEEF);
        access(1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF);
        chk("rdata0_hold", rdata0, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF);

        sb.push_back('{port: 1'b0, is_err: 1'b0, rdata: 32'hDEAD_BEEF});
        sb.push_back('{port: 1'b1, is_err: 1'b0, rdata: 32'd0});
        sb.push_back('{port: 1'b0, is_err: 1'b0, rdata: 32'hDEAD_BEEF});
        sb.push_back('{port: 1'b1, is_err: 1'b0, rdata: 32'd0});
        both_loads(32'h10, 32'h14, 8, pa0, pa1, pb);
        chk("alt_ack0_pattern", {24'd0, pa0}, 32'h11);
        chk("alt_ack1_pattern", {24'd0, pa1}, 32'h44);
        chk("alt_busy_pattern", {24'd0, pb}, 32'h55);

        access(1'b1, 1'b1, 32'h13, 32'hAAAA_5555, 1'b1, 32'd0);
        access(1'b1, 1'b1, 32'h3000, 32'hAAAA_5555, 1'b1, 32'd0);
        chk("err_dm_word4", dm[4], 32'hDEAD_BEEF);
        chk("err_dm_word0", dm[0], 32'd0);

        w0 = we_cnt;
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'd5);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("rst_resp_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_resp_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_resp_write_kept", dm[8], 32'd5);
        chk("rst_resp_store_count", we_cnt - w0, 32'd1);
        sb.push_back('{port: 1'b0, is_err: 1'b0, rdata: 32'd5});
        sb.push_back('{port: 1'b1, is_err: 1'b0, rdata: 32'hDEAD_BEEF});
        both_loads(32'h20, 32'h10, 4, pa0, pa1, pb);
        chk("post_rst_prio", {24'd0, pa0[3:0], pa1[3:0]}, 32'h14);

        access(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0);
        access(1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 32'd0);
        access(1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'd5);
        sb.push_back('{port: 1'b0, is_err: 1'b0, rdata: 32'hDEAD_BEEF});
        sb.push_back('{port: 1'b1, is_err: 1'b0, rdata: 32'hDEAD_BEEF});
        both_loads(32'h10, 32'h10, 4, pa0, pa1, pb);
        chk("after_p1_prio", {24'd0, pa0[3:0], pa1[3:0]}, 32'h14);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
